// File: rtl/ahb_slave_arbiter.sv
// ahb_slave_arbiter: per-slave address-phase arbiter for a multi-master AHB matrix.
// Round-robin ownership with locked-transfer support. The grant, owner index and
// FSM state are registered, and the data-phase owner follows on accepted cycles.
// Optional build macro AHB_ARB_HOLD_TIMEOUT_EN adds a beat counter. It forces an
// unlocked owner to release after HOLD_MAX accepted beats.
module ahb_slave_arbiter #(
    parameter int SLAVE_X_MASTER_NUM = 2,
    parameter int MASTER_ID_WIDTH    = 1,
    parameter int HOLD_MAX           = 16
) (
    input  logic                            hclk,
    input  logic                            hreset_n,
    input  logic [SLAVE_X_MASTER_NUM-1:0]   hreq,
    input  logic [2*SLAVE_X_MASTER_NUM-1:0] htrans_m,
    input  logic [SLAVE_X_MASTER_NUM-1:0]   hmastlock_m,
    input  logic                            hready,
    output logic [SLAVE_X_MASTER_NUM-1:0]   hgrant,
    output logic                            hsel,
    output logic [MASTER_ID_WIDTH-1:0]      hmaster,
    output logic [MASTER_ID_WIDTH-1:0]      hmaster_data
);

    localparam int         N          = SLAVE_X_MASTER_NUM;
    localparam logic [1:0] TR_IDLE    = 2'b00;
    localparam logic [1:0] TR_NONSEQ  = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_LOCK} state_t;

    state_t                     state;
    state_t                     state_nx;
    logic [N-1:0]               grant_nx;
    logic [MASTER_ID_WIDTH-1:0] master_nx;
    logic [MASTER_ID_WIDTH-1:0] last;
    logic                       owner_req;
    logic                       owner_lock;
    logic [1:0]                 owner_trans;
    logic                       rr_found;
    logic [MASTER_ID_WIDTH-1:0] rr_winner;
    logic                       keep;
    logic                       arb_now;
    logic                       hold_expired;

    // The live request, transfer type and lock of whoever currently owns the address phase.
    assign owner_req   = hreq[hmaster];
    assign owner_lock  = hmastlock_m[hmaster];
    assign owner_trans = htrans_m[{hmaster, 1'b0} +: 2];

    // hsel needs a real owner and an active transfer. IDLE and BUSY do not select the slave.
    assign hsel = (state != ST_IDLE) && owner_trans[1];

    // Round-robin search, starting one past the last owner. The last owner is checked last,
    // so it keeps the bus only when nobody else is requesting.
    always_comb begin
        int idx;
        idx       = 0;
        rr_found  = 1'b0;
        rr_winner = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!rr_found && hreq[idx]) begin
                rr_found  = 1'b1;
                rr_winner = MASTER_ID_WIDTH'(idx);
            end
        end
    end

    // Next-state logic. IDLE re-arbitrates every cycle. OWN and LOCK move only on accepted cycles.
    always_comb begin
        state_nx  = state;
        grant_nx  = hgrant;
        master_nx = hmaster;
        arb_now   = 1'b0;
        keep      = owner_req && (owner_trans != TR_IDLE) &&
                    !(hold_expired && (owner_trans == TR_NONSEQ));
        case (state)
            ST_IDLE: arb_now = 1'b1;
            ST_OWN: begin
                if (hready) begin
                    if (owner_lock) state_nx = ST_LOCK;
                    else if (!keep) arb_now = 1'b1;
                end
            end
            ST_LOCK: begin
                if (hready && !owner_lock) begin
                    if (keep) state_nx = ST_OWN;
                    else      arb_now  = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (arb_now) begin
            grant_nx = '0;
            if (rr_found) begin
                state_nx            = ST_OWN;
                grant_nx[rr_winner] = 1'b1;
                master_nx           = rr_winner;
            end else begin
                state_nx = ST_IDLE;
            end
        end
    end

    // Registered arbitration result. Reset leaves master 0 first in round-robin order.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state   <= ST_IDLE;
            hgrant  <= '0;
            hmaster <= '0;
            last    <= MASTER_ID_WIDTH'(N - 1);
        end else begin
            state   <= state_nx;
            hgrant  <= grant_nx;
            hmaster <= master_nx;
            if (arb_now && rr_found) last <= rr_winner;
        end
    end

    // The data-phase owner follows the address-phase owner whenever the slave accepts.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n)   hmaster_data <= '0;
        else if (hready) hmaster_data <= hmaster;
    end

`ifdef AHB_ARB_HOLD_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    logic [CNT_W-1:0] hold_cnt;

    // Counts accepted NONSEQ/SEQ beats of an unlocked owner. Saturates at HOLD_MAX and
    // clears on every arbitration.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n)
            hold_cnt <= '0;
        else if (arb_now)
            hold_cnt <= '0;
        else if (hready && (state == ST_OWN) && owner_trans[1] && (hold_cnt < CNT_W'(HOLD_MAX)))
            hold_cnt <= hold_cnt + CNT_W'(1);
    end

    assign hold_expired = (hold_cnt >= CNT_W'(HOLD_MAX));
`else
    // Without the timeout build the owner is never forced off. This comparison is always false.
    assign hold_expired = (HOLD_MAX < 0);
`endif

endmodule

// File: doc/ahb_slave_arbiter.md
AHB_SLAVE_ARBITER -- requirements
Module: ahb_slave_arbiter

Interface
REQ-001 SHALL have parameter SLAVE_X_MASTER_NUM, default 2, number of masters sharing this slave (2..16).
REQ-002 SHALL have parameter MASTER_ID_WIDTH, default 1, index width, at least max(1, clog2(SLAVE_X_MASTER_NUM)).
REQ-003 SHALL have parameter HOLD_MAX, default 16, accepted-beat limit before forced release (used only under REQ-030).
REQ-004 SHALL have port hclk, input, 1, the single clock; all state on its rising edge.
REQ-005 SHALL have port hreset_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port hreq, input, SLAVE_X_MASTER_NUM, per-master request, bit i from master i's address decoder.
REQ-007 SHALL have port htrans_m, input, SLAVE_X_MASTER_NUM x 2, per-master htrans: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 SHALL have port hmastlock_m, input, SLAVE_X_MASTER_NUM, per-master locked-transfer flag.
REQ-009 SHALL have port hready, input, 1, slave hreadyout; 1 = current address phase accepted.
REQ-010 SHALL have port hgrant, output, SLAVE_X_MASTER_NUM, one-hot or zero address-phase grant.
REQ-011 SHALL have port hsel, output, 1, slave select: owner exists and owner htrans_m is NONSEQ or SEQ.
REQ-012 SHALL have port hmaster, output, MASTER_ID_WIDTH, address-phase owner index.
REQ-013 SHALL have port hmaster_data, output, MASTER_ID_WIDTH, data-phase owner index for the response/wdata mux.

Function
REQ-014 SHALL implement a three-state FSM: IDLE (no owner), OWN (owner, unlocked), LOCK (owner, hmastlock_m set).
REQ-015 SHALL register hgrant, hmaster and the FSM state: an arbitration decision at edge t drives outputs from cycle t+1.
REQ-016 SHALL, in IDLE, arbitrate every cycle regardless of hready; with any hreq set, go to OWN with the winner; otherwise stay IDLE.
REQ-017 SHALL pick the winner round-robin: the first set hreq bit scanning upward from (last owner + 1) mod SLAVE_X_MASTER_NUM.
REQ-018 SHALL change ownership in OWN/LOCK only on a cycle with hready=1; with hready=0, grant, state and counter hold.
REQ-019 SHALL keep OWN while hready=1, owner hreq=1 and owner htrans_m is not IDLE.
REQ-020 SHALL release in OWN when hready=1 and (owner hreq=0 or owner htrans_m=IDLE): re-arbitrate the same cycle; winner -> OWN, none -> IDLE.
REQ-021 SHALL enter LOCK from OWN on the accepted cycle where the owner's hmastlock_m=1, and stay while it remains 1, ignoring release conditions.
REQ-022 SHALL exit LOCK on the first accepted cycle with owner hmastlock_m=0, then evaluate REQ-019/REQ-020 in that same cycle.
REQ-023 SHALL let the owner keep the bus on a simultaneous release and re-request only if no other master requests (round-robin excludes it first).
REQ-024 SHALL load hmaster_data from hmaster on every hready=1 cycle and hold it otherwise.
REQ-025 SHALL drive hsel combinationally from the registered owner and the live owner htrans_m; hsel=0 in IDLE and for BUSY.
REQ-026 SHALL update the last-owner pointer only when a new grant is issued.

Reset
REQ-027 SHALL, on hreset_n=0, immediately force: state IDLE, hgrant=0, hsel=0, hmaster=0, hmaster_data=0, hold counter=0.
REQ-028 SHALL set the last-owner pointer to SLAVE_X_MASTER_NUM-1 at reset, so master 0 wins the first arbitration.
REQ-029 SHALL, when reset asserts mid-burst, drop the grant with no completion; after release, arbitrate afresh from IDLE.

Configuration
REQ-030 SHALL, with macro AHB_ARB_HOLD_TIMEOUT_EN defined, count accepted NONSEQ/SEQ beats in OWN and, once count >= HOLD_MAX, release at the next accepted NONSEQ or IDLE beat, counter cleared on every grant change.
REQ-031 SHALL, without AHB_ARB_HOLD_TIMEOUT_EN, contain no hold counter and release only per REQ-020/REQ-022; LOCK is never timed out in either build.

Verification
REQ-032 SHALL cover: N=2, hreq=11 from reset, both NONSEQ, hready=1 -> hgrant=01 at cycle 1, hmaster=0, hmaster_data=0 at cycle 2.
REQ-033 SHALL cover: master 0 owning, 4-beat SEQ burst then IDLE, master 1 requesting throughout -> hgrant stays 01 through beats, becomes 10 the cycle after the IDLE beat.
REQ-034 SHALL cover: hready=0 for 3 cycles while owner goes IDLE -> hgrant and hmaster unchanged until hready=1, then switch.
REQ-035 SHALL cover: owner hmastlock_m=1 with htrans_m IDLE and other hreq set -> state LOCK, hgrant unchanged until hmastlock_m drops.
REQ-036 SHALL cover: AHB_ARB_HOLD_TIMEOUT_EN, HOLD_MAX=4, master 0 issuing back-to-back NONSEQ singles, master 1 requesting -> grant passes to master 1 after the 5th accepted beat.
REQ-037 SHALL cover: hreset_n low mid-burst -> hgrant=0, hsel=0 asynchronously; after release with hreq=10 -> hgrant=10.
